mips_harvard_bus_bridge: RTL and testbench

MIPS_HARVARD_BUS_BRIDGE -- requirements
Module: mips_harvard_bus_bridge

---
 rtl/mips_harvard_bus_bridge_pkg.sv | 18 +
 rtl/mips_harvard_bus_bridge_watchdog.sv | 49 ++++
 rtl/mips_harvard_bus_bridge.sv | 212 +++++++++++++++++++++
 tb/tb_mips_harvard_bus_bridge.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_harvard_bus_bridge_pkg.sv
// Shared definitions for the MIPS Harvard-to-single-bus bridge.
//   state_e                : bridge FSM states
//   BYTE_EN_ALL            : full-word byte-lane mask used for instruction fetches
//   DEFAULT_TIMEOUT_CYCLES : default watchdog limit in consecutive waitrequest cycles
package mips_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DATA   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  localparam logic [3:0] BYTE_EN_ALL            = 4'hF;
  localparam int         DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mips_harvard_bus_bridge_watchdog.sv
// bus_watchdog: saturating counter of consecutive stalled bus cycles.
//   clk, reset : clock and asynchronous active-high reset
//   active     : bridge is in a transfer state (FETCH or DATA)
//   stall      : slave is holding waitrequest high
//   timeout    : high on the stalled cycle that brings the count to TIMEOUT_CYCLES
// The count clears whenever a transfer completes or the bridge leaves a
// transfer state, and it never wraps past TIMEOUT_CYCLES.
module bus_watchdog
  import mips_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic stall,
  output logic timeout
);

  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = '0;
    timeout = 1'b0;
    if (active && stall) begin
      if (count_q != CNT_MAX) begin
        count_d = count_q + CNT_W'(1);
      end else begin
        count_d = count_q;
      end
      // Flag on the cycle the count is about to reach the limit so the FSM
      // can leave the transfer on this same edge.
      timeout = (count_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mips_harvard_bus_bridge.sv
// mips_harvard_bus_bridge: serialises a MIPS CPU's separate instruction and
// data ports onto one waitrequest-style memory bus.
//   clk, reset                         : clock, asynchronous active-high reset
//   cpu_active, instr_read             : CPU running flag and fetch request
//   instr_address / instr_readdata     : fetch PC and latched instruction word
//   data_read, data_write, data_address,
//   data_writedata, byte_enable        : CPU load/store request
//   data_readdata                      : latched load data
//   clk_enable                         : one-cycle CPU advance strobe per instruction
//   bus_address, bus_read, bus_write,
//   bus_writedata, bus_byteenable      : registered bus request (held during stalls)
//   bus_waitrequest, bus_readdata      : slave stall and read data
//   bus_error                          : sticky watchdog timeout flag
// Each instruction runs FETCH, optionally DATA, then COMMIT. All bus outputs are
// registers loaded on the edge that enters a transfer state, so they cannot
// move while the slave stalls even if the CPU inputs change.
module mips_harvard_bus_bridge
  import mips_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_active,
  input  logic        instr_read,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writedata,
  input  logic [3:0]  byte_enable,
  output logic [31:0] data_readdata,
  output logic        clk_enable,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_writedata,
  output logic [3:0]  bus_byteenable,
  input  logic        bus_waitrequest,
  input  logic [31:0] bus_readdata,
  output logic        bus_error
);

  state_e      state_q, state_d;
  logic [31:0] instr_readdata_q, instr_readdata_d;
  logic [31:0] data_readdata_q, data_readdata_d;
  logic [31:0] bus_address_q, bus_address_d;
  logic        bus_read_q, bus_read_d;
  logic        bus_write_q, bus_write_d;
  logic [31:0] bus_writedata_q, bus_writedata_d;
  logic [3:0]  bus_byteenable_q, bus_byteenable_d;
  logic        bus_error_q, bus_error_d;

  logic xfer_active;
  logic timeout;

  // Bus addresses are word aligned; the low CPU address bits are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_address[1:0], data_address[1:0]};

  assign xfer_active = (state_q == ST_FETCH) || (state_q == ST_DATA);

  bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .active  (xfer_active),
    .stall   (bus_waitrequest),
    .timeout (timeout)
  );

  always_comb begin
    state_d          = state_q;
    instr_readdata_d = instr_readdata_q;
    data_readdata_d  = data_readdata_q;
    bus_address_d    = bus_address_q;
    bus_read_d       = bus_read_q;
    bus_write_d      = bus_write_q;
    bus_writedata_d  = bus_writedata_q;
    bus_byteenable_d = bus_byteenable_q;
    bus_error_d      = bus_error_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_active && instr_read) begin
          state_d          = ST_FETCH;
          bus_address_d    = {instr_address[31:2], 2'b00};
          bus_read_d       = 1'b1;
          bus_write_d      = 1'b0;
          bus_writedata_d  = '0;
          bus_byteenable_d = BYTE_EN_ALL;
        end
      end

      ST_FETCH: begin
        if (timeout) begin
          state_d          = ST_FAULT;
          bus_error_d      = 1'b1;
          bus_address_d    = '0;
          bus_read_d       = 1'b0;
          bus_write_d      = 1'b0;
          bus_writedata_d  = '0;
          bus_byteenable_d = '0;
        end else if (!bus_waitrequest) begin
          instr_readdata_d = bus_readdata;
          if (data_read || data_write) begin
            state_d          = ST_DATA;
            bus_address_d    = {data_address[31:2], 2'b00};
            bus_byteenable_d = byte_enable;
            // A simultaneous read and write request performs the store only.
            if (data_write) begin
              bus_read_d      = 1'b0;
              bus_write_d     = 1'b1;
              bus_writedata_d = data_writedata;
            end else begin
              bus_read_d      = 1'b1;
              bus_write_d     = 1'b0;
              bus_writedata_d = '0;
            end
          end else begin
            state_d          = ST_COMMIT;
            bus_address_d    = '0;
            bus_read_d       = 1'b0;
            bus_write_d      = 1'b0;
            bus_writedata_d  = '0;
            bus_byteenable_d = '0;
          end
        end
      end

      ST_DATA: begin
        if (timeout) begin
          state_d          = ST_FAULT;
          bus_error_d      = 1'b1;
          bus_address_d    = '0;
          bus_read_d       = 1'b0;
          bus_write_d      = 1'b0;
          bus_writedata_d  = '0;
          bus_byteenable_d = '0;
        end else if (!bus_waitrequest) begin
          if (bus_read_q) begin
            data_readdata_d = bus_readdata;
          end
          state_d          = ST_COMMIT;
          bus_address_d    = '0;
          bus_read_d       = 1'b0;
          bus_write_d      = 1'b0;
          bus_writedata_d  = '0;
          bus_byteenable_d = '0;
        end
      end

      ST_COMMIT: begin
        if (cpu_active) begin
          state_d          = ST_FETCH;
          bus_address_d    = {instr_address[31:2], 2'b00};
          bus_read_d       = 1'b1;
          bus_write_d      = 1'b0;
          bus_writedata_d  = '0;
          bus_byteenable_d = BYTE_EN_ALL;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      instr_readdata_q <= '0;
      data_readdata_q  <= '0;
      bus_address_q    <= '0;
      bus_read_q       <= 1'b0;
      bus_write_q      <= 1'b0;
      bus_writedata_q  <= '0;
      bus_byteenable_q <= '0;
      bus_error_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      instr_readdata_q <= instr_readdata_d;
      data_readdata_q  <= data_readdata_d;
      bus_address_q    <= bus_address_d;
      bus_read_q       <= bus_read_d;
      bus_write_q      <= bus_write_d;
      bus_writedata_q  <= bus_writedata_d;
      bus_byteenable_q <= bus_byteenable_d;
      bus_error_q      <= bus_error_d;
    end
  end

  assign clk_enable     = (state_q == ST_COMMIT);
  assign instr_readdata = instr_readdata_q;
  assign data_readdata  = data_readdata_q;
  assign bus_address    = bus_address_q;
  assign bus_read       = bus_read_q;
  assign bus_write      = bus_write_q;
  assign bus_writedata  = bus_writedata_q;
  assign bus_byteenable = bus_byteenable_q;
  assign bus_error      = bus_error_q;

endmodule

// File: tb/tb_mips_harvard_bus_bridge.sv
// Testbench for mips_harvard_bus_bridge. The bench plays the bus slave and the
// CPU; each instruction is described as a transaction (addresses, data, wait
// counts) and the expected per-cycle bus activity is derived from that
// transaction: FETCH for fetch-waits+1 cycles, optional DATA for data-waits+1
// cycles, then one COMMIT cycle.
module tb_mips_harvard_bus_bridge;

  logic        clk;
  logic        reset;
  logic        cpu_active;
  logic        instr_read;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic [3:0]  byte_enable;
  logic [31:0] data_readdata;
  logic        clk_enable;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic [3:0]  bus_byteenable;
  logic        bus_waitrequest;
  logic [31:0] bus_readdata;
  logic        bus_error;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [31:0] exp_ird = '0;
  logic [31:0] exp_drd = '0;

  mips_harvard_bus_bridge #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_active      (cpu_active),
    .instr_read      (instr_read),
    .instr_address   (instr_address),
    .instr_readdata  (instr_readdata),
    .data_read       (data_read),
    .data_write      (data_write),
    .data_address    (data_address),
    .data_writedata  (data_writedata),
    .byte_enable     (byte_enable),
    .data_readdata   (data_readdata),
    .clk_enable      (clk_enable),
    .bus_address     (bus_address),
    .bus_read        (bus_read),
    .bus_write       (bus_write),
    .bus_writedata   (bus_writedata),
    .bus_byteenable  (bus_byteenable),
    .bus_waitrequest (bus_waitrequest),
    .bus_readdata    (bus_readdata),
    .bus_error       (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_xfer(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd);
    chk({tag, ".bus_read"},       32'(bus_read),       32'(rd));
    chk({tag, ".bus_write"},      32'(bus_write),      32'(wr));
    chk({tag, ".bus_address"},    bus_address,         addr);
    chk({tag, ".bus_byteenable"}, 32'(bus_byteenable), 32'(be));
    chk({tag, ".bus_writedata"},  bus_writedata,       wd);
    chk({tag, ".clk_enable"},     32'(clk_enable),     32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk_xfer(tag, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk({tag, ".bus_error"}, 32'(bus_error), 32'd0);
  endtask

  // Called in the cycle before FETCH (IDLE or COMMIT); returns in the COMMIT
  // cycle with cpu_active set for the cycle after it.
  task automatic run_instr(input logic [31:0] ia, input logic [31:0] iw, input int kind,
                           input logic [31:0] da, input logic [31:0] wd, input logic [3:0] be,
                           input logic [31:0] rdat, input int fw, input int dw,
                           input logic drop, input logic nxt);
    logic rd;
    logic wr;
    cpu_active     = 1'b1;
    instr_read     = 1'b1;
    instr_address  = ia;
    data_read      = (kind == 1) || (kind == 3);
    data_write     = (kind >= 2);
    data_address   = da;
    data_writedata = wd;
    byte_enable    = be;
    step();
    if (drop) cpu_active = 1'b0;
    for (int k = 0; k <= fw; k++) begin
      bus_waitrequest = (k < fw);
      bus_readdata    = (k < fw) ? $urandom : iw;
      chk_xfer("fetch", 1'b1, 1'b0, {ia[31:2], 2'b00}, 4'hF, 32'h0);
      step();
    end
    exp_ird = iw;
    if (kind != 0) begin
      wr = (kind >= 2);
      rd = !wr;
      for (int k = 0; k <= dw; k++) begin
        bus_waitrequest = (k < dw);
        bus_readdata    = (k < dw) ? $urandom : rdat;
        chk_xfer("data", rd, wr, {da[31:2], 2'b00}, be, wr ? wd : 32'h0);
        step();
      end
      if (rd) exp_drd = rdat;
    end
    bus_waitrequest = 1'($urandom);
    chk("commit.clk_enable",     32'(clk_enable), 32'd1);
    chk("commit.bus_read",       32'(bus_read),   32'd0);
    chk("commit.bus_write",      32'(bus_write),  32'd0);
    chk("commit.instr_readdata", instr_readdata,  exp_ird);
    chk("commit.data_readdata",  data_readdata,   exp_drd);
    cpu_active = drop ? 1'b0 : nxt;
  endtask

  initial begin
    logic [31:0] r_ia, r_iw, r_da, r_wd, r_rd;
    logic [3:0]  r_be;
    int          r_kind, r_fw, r_dw;
    logic        r_drop, r_nxt;

    reset = 1'b1;
    cpu_active = 1'b1; instr_read = 1'b1; instr_address = 32'hBFC00000;
    data_read = 1'b0; data_write = 1'b0; data_address = '0;
    data_writedata = '0; byte_enable = '0;
    bus_waitrequest = 1'b0; bus_readdata = '0;
    step(); step();
    chk_idle("reset");
    chk("reset.instr_readdata", instr_readdata, 32'h0);
    chk("reset.data_readdata",  data_readdata,  32'h0);
    cpu_active = 1'b0;
    reset = 1'b0;
    step();
    chk_idle("post_reset_idle");

    // Zero-wait ALU instruction
    run_instr(32'hBFC00004, 32'h24020005, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 0, 1'b0, 1'b1);
    // Load with two wait cycles on the data phase
    run_instr(32'hBFC00008, 32'h8C820006, 1, 32'h00001006, 32'h0, 4'hF, 32'hDEADBEEF, 0, 2, 1'b0, 1'b1);
    // Halfword-lane store
    run_instr(32'hBFC0000C, 32'hAC830000, 2, 32'h00002000, 32'h12345678, 4'b0011, 32'h0, 1, 0, 1'b0, 1'b1);
    // Read and write together: store only, load data unchanged
    run_instr(32'hBFC00010, 32'h00000000, 3, 32'h00003008, 32'hCAFEF00D, 4'b1100, 32'h55555555, 0, 1, 1'b0, 1'b0);
    // cpu_active low at COMMIT: back to IDLE with no further strobes
    instr_read = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_idle("idle_after_commit");
    end

    for (int i = 0; i < 40; i++) begin
      r_ia = $urandom; r_iw = $urandom; r_da = $urandom; r_wd = $urandom;
      r_rd = $urandom; r_be = 4'($urandom);
      r_kind = $urandom_range(0, 3);
      r_fw = $urandom_range(0, 2);
      r_dw = $urandom_range(0, 2);
      r_drop = ($urandom_range(0, 5) == 0);
      r_nxt = ($urandom_range(0, 3) != 0);
      run_instr(r_ia, r_iw, r_kind, r_da, r_wd, r_be, r_rd, r_fw, r_dw, r_drop, r_nxt);
      if (!cpu_active) begin
        step();
        chk_idle("rand_idle");
        instr_read = 1'($urandom);
        step();
        chk_idle("rand_idle2");
      end
    end

    // Asynchronous reset in the middle of a stalled data read
    cpu_active = 1'b1; instr_read = 1'b1; instr_address = 32'h00400000;
    data_read = 1'b1; data_write = 1'b0; data_address = 32'h00002000; byte_enable = 4'hF;
    bus_waitrequest = 1'b0; bus_readdata = 32'h11112222;
    step();
    chk_xfer("rst_fetch", 1'b1, 1'b0, 32'h00400000, 4'hF, 32'h0);
    step();
    bus_waitrequest = 1'b1;
    chk_xfer("rst_data", 1'b1, 1'b0, 32'h00002000, 4'hF, 32'h0);
    #2 reset = 1'b1;
    #1;
    chk_idle("async_reset");
    chk("async_reset.instr_readdata", instr_readdata, 32'h0);
    chk("async_reset.data_readdata",  data_readdata,  32'h0);
    #1 reset = 1'b0;
    data_read = 1'b0;
    bus_waitrequest = 1'b0;
    exp_drd = 32'h0;
    @(posedge clk);
    #1;
    chk_xfer("refetch", 1'b1, 1'b0, 32'h00400000, 4'hF, 32'h0);
    chk("refetch.instr_readdata", instr_readdata, 32'h0);
    cpu_active = 1'b0;
    step();
    chk("refetch.commit.clk_enable",     32'(clk_enable), 32'd1);
    chk("refetch.commit.instr_readdata", instr_readdata,  32'h11112222);
    chk("refetch.commit.data_readdata",  data_readdata,   32'h0);
    step();
    chk_idle("refetch_idle");

    // Watchdog timeout with waitrequest stuck high
    cpu_active = 1'b1; instr_read = 1'b1; instr_address = 32'hBFC00000;
    bus_waitrequest = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("to.bus_read",   32'(bus_read),   32'd1);
      chk("to.bus_error",  32'(bus_error),  32'd0);
      chk("to.clk_enable", 32'(clk_enable), 32'd0);
      step();
    end
    chk("fault.bus_error", 32'(bus_error), 32'd1);
    chk("fault.bus_read",  32'(bus_read),  32'd0);
    chk("fault.bus_write", 32'(bus_write), 32'd0);
    bus_waitrequest = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("fault.clk_enable", 32'(clk_enable), 32'd0);
      chk("fault.sticky",     32'(bus_error),  32'd1);
      chk("fault.strobe",     32'(bus_read | bus_write), 32'd0);
      step();
    end
    #2 reset = 1'b1;
    #1;
    chk("fault_reset.bus_error", 32'(bus_error), 32'd0);
    #1 reset = 1'b0;
    cpu_active = 1'b0;
    step();
    chk_idle("after_fault_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
